jelly2_wishbone_to_axi4l: RTL and testbench

//  Bridge from a WISHBONE classic slave port to an AXI4-Lite master port; inverse of the AXI4-Lite->WISHBONE peripheral bridge.

---
 rtl/jelly2_wishbone_to_axi4l.sv | 194 +++++++++++++++++++
 tb/tb_jelly2_wishbone_to_axi4l.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly2_wishbone_to_axi4l.sv
// rtl/jelly2_wishbone_to_axi4l.sv - WISHBONE classic slave to AXI4-Lite master bridge
// One transaction in flight; every output comes straight from a register.

module jelly2_wishbone_to_axi4l #(
  parameter int          WB_DAT_SIZE      = 3,
  parameter int          WB_ADR_WIDTH     = 37,
  parameter int          AXI4L_ADDR_WIDTH = 40,
  parameter logic [2:0]  AXI4L_PROT       = 3'b000,
  localparam int         DAT_WIDTH        = 8 << WB_DAT_SIZE,
  localparam int         SEL_WIDTH        = 1 << WB_DAT_SIZE
) (
  input  logic                          reset,
  input  logic                          clk,

  input  logic [WB_ADR_WIDTH-1:0]       s_wb_adr_i,
  input  logic [DAT_WIDTH-1:0]          s_wb_dat_i,
  output logic [DAT_WIDTH-1:0]          s_wb_dat_o,
  input  logic [SEL_WIDTH-1:0]          s_wb_sel_i,
  input  logic                          s_wb_we_i,
  input  logic                          s_wb_stb_i,
  output logic                          s_wb_ack_o,
  output logic                          resp_err,

  output logic [AXI4L_ADDR_WIDTH-1:0]   m_axi4l_awaddr,
  output logic [2:0]                    m_axi4l_awprot,
  output logic                          m_axi4l_awvalid,
  input  logic                          m_axi4l_awready,
  output logic [DAT_WIDTH-1:0]          m_axi4l_wdata,
  output logic [SEL_WIDTH-1:0]          m_axi4l_wstrb,
  output logic                          m_axi4l_wvalid,
  input  logic                          m_axi4l_wready,
  input  logic [1:0]                    m_axi4l_bresp,
  input  logic                          m_axi4l_bvalid,
  output logic                          m_axi4l_bready,
  output logic [AXI4L_ADDR_WIDTH-1:0]   m_axi4l_araddr,
  output logic [2:0]                    m_axi4l_arprot,
  output logic                          m_axi4l_arvalid,
  input  logic                          m_axi4l_arready,
  input  logic [DAT_WIDTH-1:0]          m_axi4l_rdata,
  input  logic [1:0]                    m_axi4l_rresp,
  input  logic                          m_axi4l_rvalid,
  output logic                          m_axi4l_rready
);

  // Wide enough for both the shifted word address and the AXI address, so
  // the conversion is a zero-extend or a truncate depending on parameters.
  localparam int ADR_FULL = (WB_ADR_WIDTH + WB_DAT_SIZE > AXI4L_ADDR_WIDTH)
                          ? (WB_ADR_WIDTH + WB_DAT_SIZE) : AXI4L_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_WAIT_B, ST_READ, ST_WAIT_R, ST_ACK
  } state_t;

  state_t                        state, state_next;
  logic [AXI4L_ADDR_WIDTH-1:0]   addr_q, addr_next;
  logic [DAT_WIDTH-1:0]          wdata_q, wdata_next;
  logic [SEL_WIDTH-1:0]          wstrb_q, wstrb_next;
  logic [DAT_WIDTH-1:0]          rdata_q, rdata_next;
  logic                          awvalid_q, awvalid_next;
  logic                          wvalid_q, wvalid_next;
  logic                          bready_q, bready_next;
  logic                          arvalid_q, arvalid_next;
  logic                          rready_q, rready_next;
  logic                          ack_q, ack_next;
  logic                          err_q, err_next;
  logic [ADR_FULL-1:0]           byte_adr;

  assign byte_adr = ADR_FULL'(s_wb_adr_i) << WB_DAT_SIZE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      addr_q    <= addr_next;
      wdata_q   <= wdata_next;
      wstrb_q   <= wstrb_next;
      rdata_q   <= rdata_next;
      awvalid_q <= awvalid_next;
      wvalid_q  <= wvalid_next;
      bready_q  <= bready_next;
      arvalid_q <= arvalid_next;
      rready_q  <= rready_next;
      ack_q     <= ack_next;
      err_q     <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    addr_next    = addr_q;
    wdata_next   = wdata_q;
    wstrb_next   = wstrb_q;
    rdata_next   = rdata_q;
    awvalid_next = awvalid_q;
    wvalid_next  = wvalid_q;
    bready_next  = bready_q;
    arvalid_next = arvalid_q;
    rready_next  = rready_q;
    ack_next     = 1'b0;
    err_next     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (s_wb_stb_i) begin
          addr_next  = byte_adr[AXI4L_ADDR_WIDTH-1:0];
          wdata_next = s_wb_dat_i;
          wstrb_next = s_wb_sel_i;
          if (s_wb_we_i) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = ST_WRITE;
          end else begin
            arvalid_next = 1'b1;
            state_next   = ST_READ;
          end
        end
      end

      // Address and data channels retire independently, in either order.
      ST_WRITE: begin
        if (awvalid_q && m_axi4l_awready) awvalid_next = 1'b0;
        if (wvalid_q && m_axi4l_wready)   wvalid_next  = 1'b0;
        if (!awvalid_next && !wvalid_next) begin
          bready_next = 1'b1;
          state_next  = ST_WAIT_B;
        end
      end

      ST_WAIT_B: begin
        if (m_axi4l_bvalid) begin
          bready_next = 1'b0;
          ack_next    = 1'b1;
          err_next    = (m_axi4l_bresp != 2'b00);
          state_next  = ST_ACK;
        end
      end

      ST_READ: begin
        if (m_axi4l_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = ST_WAIT_R;
        end
      end

      ST_WAIT_R: begin
        if (m_axi4l_rvalid) begin
          rready_next = 1'b0;
          rdata_next  = m_axi4l_rdata;
          ack_next    = 1'b1;
          err_next    = (m_axi4l_rresp != 2'b00);
          state_next  = ST_ACK;
        end
      end

      // stb is still high from the finished cycle here, so it is not sampled.
      ST_ACK: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign s_wb_dat_o      = rdata_q;
  assign s_wb_ack_o      = ack_q;
  assign resp_err        = err_q;
  assign m_axi4l_awaddr  = addr_q;
  assign m_axi4l_awprot  = AXI4L_PROT;
  assign m_axi4l_awvalid = awvalid_q;
  assign m_axi4l_wdata   = wdata_q;
  assign m_axi4l_wstrb   = wstrb_q;
  assign m_axi4l_wvalid  = wvalid_q;
  assign m_axi4l_bready  = bready_q;
  assign m_axi4l_araddr  = addr_q;
  assign m_axi4l_arprot  = AXI4L_PROT;
  assign m_axi4l_arvalid = arvalid_q;
  assign m_axi4l_rready  = rready_q;

endmodule

// File: tb/tb_jelly2_wishbone_to_axi4l.sv
// tb/tb_jelly2_wishbone_to_axi4l.sv - bench for the WISHBONE to AXI4-Lite bridge
// AXI slave with programmable stalls plus a word-level memory model on the WISHBONE side.

module tb_jelly2_wishbone_to_axi4l;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic [36:0] s_wb_adr_i = '0;
  logic [63:0] s_wb_dat_i = '0;
  logic [63:0] s_wb_dat_o;
  logic [7:0]  s_wb_sel_i = '0;
  logic        s_wb_we_i  = 1'b0;
  logic        s_wb_stb_i = 1'b0;
  logic        s_wb_ack_o;
  logic        resp_err;
  logic [39:0] m_axi4l_awaddr;
  logic [2:0]  m_axi4l_awprot;
  logic        m_axi4l_awvalid;
  logic        m_axi4l_awready = 1'b0;
  logic [63:0] m_axi4l_wdata;
  logic [7:0]  m_axi4l_wstrb;
  logic        m_axi4l_wvalid;
  logic        m_axi4l_wready = 1'b0;
  logic [1:0]  m_axi4l_bresp = 2'b00;
  logic        m_axi4l_bvalid = 1'b0;
  logic        m_axi4l_bready;
  logic [39:0] m_axi4l_araddr;
  logic [2:0]  m_axi4l_arprot;
  logic        m_axi4l_arvalid;
  logic        m_axi4l_arready = 1'b0;
  logic [63:0] m_axi4l_rdata = '0;
  logic [1:0]  m_axi4l_rresp = 2'b00;
  logic        m_axi4l_rvalid = 1'b0;
  logic        m_axi4l_rready;

  jelly2_wishbone_to_axi4l #(
    .WB_DAT_SIZE      (3),
    .WB_ADR_WIDTH     (37),
    .AXI4L_ADDR_WIDTH (40),
    .AXI4L_PROT       (3'b000)
  ) dut (
    .reset           (reset),
    .clk             (clk),
    .s_wb_adr_i      (s_wb_adr_i),
    .s_wb_dat_i      (s_wb_dat_i),
    .s_wb_dat_o      (s_wb_dat_o),
    .s_wb_sel_i      (s_wb_sel_i),
    .s_wb_we_i       (s_wb_we_i),
    .s_wb_stb_i      (s_wb_stb_i),
    .s_wb_ack_o      (s_wb_ack_o),
    .resp_err        (resp_err),
    .m_axi4l_awaddr  (m_axi4l_awaddr),
    .m_axi4l_awprot  (m_axi4l_awprot),
    .m_axi4l_awvalid (m_axi4l_awvalid),
    .m_axi4l_awready (m_axi4l_awready),
    .m_axi4l_wdata   (m_axi4l_wdata),
    .m_axi4l_wstrb   (m_axi4l_wstrb),
    .m_axi4l_wvalid  (m_axi4l_wvalid),
    .m_axi4l_wready  (m_axi4l_wready),
    .m_axi4l_bresp   (m_axi4l_bresp),
    .m_axi4l_bvalid  (m_axi4l_bvalid),
    .m_axi4l_bready  (m_axi4l_bready),
    .m_axi4l_araddr  (m_axi4l_araddr),
    .m_axi4l_arprot  (m_axi4l_arprot),
    .m_axi4l_arvalid (m_axi4l_arvalid),
    .m_axi4l_arready (m_axi4l_arready),
    .m_axi4l_rdata   (m_axi4l_rdata),
    .m_axi4l_rresp   (m_axi4l_rresp),
    .m_axi4l_rvalid  (m_axi4l_rvalid),
    .m_axi4l_rready  (m_axi4l_rready)
  );

  // Slave configuration, written only by the main sequence.
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  // Slave bookkeeping, written only by the slave process.
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          got_aw, got_w, b_pend, r_pend;
  logic [39:0] aw_addr_q, ar_addr_q;
  logic [63:0] w_data_q;
  logic [7:0]  w_strb_q;
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_high, w_high, ack_cnt;
  logic [63:0] slv_mem [logic [39:0]];

  // Decisions made at the falling edge hold through the next rising edge,
  // so valid && ready seen here is exactly a handshake at that rising edge.
  always @(negedge clk) begin
    if (reset) begin
      m_axi4l_awready = 1'b0; m_axi4l_wready = 1'b0; m_axi4l_arready = 1'b0;
      m_axi4l_bvalid = 1'b0; m_axi4l_rvalid = 1'b0;
      got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    end else begin
      if (s_wb_ack_o) ack_cnt++;
      if (b_pend) begin
        if (b_cnt >= b_dly) begin m_axi4l_bvalid = 1'b1; m_axi4l_bresp = bresp_cfg; end
        else begin m_axi4l_bvalid = 1'b0; b_cnt++; end
        if (m_axi4l_bvalid && m_axi4l_bready) begin b_hs++; b_pend = 0; end
      end else begin
        m_axi4l_bvalid = 1'b0; m_axi4l_bresp = 2'b00;
      end
      if (r_pend) begin
        if (r_cnt >= r_dly) begin
          m_axi4l_rvalid = 1'b1; m_axi4l_rresp = rresp_cfg;
          m_axi4l_rdata = slv_mem.exists(ar_addr_q) ? slv_mem[ar_addr_q] : 64'h0;
        end else begin m_axi4l_rvalid = 1'b0; r_cnt++; end
        if (m_axi4l_rvalid && m_axi4l_rready) begin r_hs++; r_pend = 0; end
      end else begin
        m_axi4l_rvalid = 1'b0; m_axi4l_rresp = 2'b00;
      end
      if (m_axi4l_awvalid) begin
        aw_high++;
        m_axi4l_awready = (aw_cnt >= aw_dly);
        if (m_axi4l_awready) begin aw_hs++; aw_addr_q = m_axi4l_awaddr; got_aw = 1; aw_cnt = 0; end
        else aw_cnt++;
      end else begin m_axi4l_awready = 1'b0; aw_cnt = 0; end
      if (m_axi4l_wvalid) begin
        w_high++;
        m_axi4l_wready = (w_cnt >= w_dly);
        if (m_axi4l_wready) begin
          w_hs++; w_data_q = m_axi4l_wdata; w_strb_q = m_axi4l_wstrb; got_w = 1; w_cnt = 0;
        end else w_cnt++;
      end else begin m_axi4l_wready = 1'b0; w_cnt = 0; end
      if (got_aw && got_w) begin
        if (!slv_mem.exists(aw_addr_q)) slv_mem[aw_addr_q] = 64'h0;
        for (int i = 0; i < 8; i++)
          if (w_strb_q[i]) slv_mem[aw_addr_q][8*i +: 8] = w_data_q[8*i +: 8];
        got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
      end
      if (m_axi4l_arvalid) begin
        m_axi4l_arready = (ar_cnt >= ar_dly);
        if (m_axi4l_arready) begin ar_hs++; ar_addr_q = m_axi4l_araddr; r_pend = 1; r_cnt = 0; ar_cnt = 0; end
        else ar_cnt++;
      end else begin m_axi4l_arready = 1'b0; ar_cnt = 0; end
    end
  end

  int          checks = 0, errors = 0;
  logic [63:0] ref_mem [logic [36:0]];
  logic [63:0] last_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one WISHBONE cycle and waits (bounded) for ack; returns one cycle after ack.
  task automatic wb_xfer(input bit we, input logic [36:0] adr, input logic [63:0] dat,
                         input logic [7:0] sel, input bit hold,
                         output int lat, output logic [63:0] rd, output logic err);
    bit ok = 0;
    s_wb_stb_i = 1'b1; s_wb_we_i = we; s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_sel_i = sel;
    lat = 0;
    while (!ok && lat < 300) begin
      @(posedge clk); #1; lat++;
      if (s_wb_ack_o) ok = 1;
    end
    rd  = s_wb_dat_o;
    err = resp_err;
    if (!hold) s_wb_stb_i = 1'b0;
    chk("ack_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;
    chk("ack_single", 64'(s_wb_ack_o), 64'd0);
    chk("err_single", 64'(resp_err), 64'd0);
  endtask

  // Runs one transaction and checks it against the word-level memory model.
  task automatic do_txn(input bit we, input logic [36:0] adr, input logic [63:0] dat,
                        input logic [7:0] sel, input bit hold,
                        input logic [1:0] bresp, input logic [1:0] rresp);
    int          lat, exp_lat;
    logic [63:0] rd, exp_rd;
    logic        err;
    logic [39:0] exp_addr;
    int aw0 = aw_hs, w0 = w_hs, b0 = b_hs, ar0 = ar_hs, r0 = r_hs;
    int awh0 = aw_high, wh0 = w_high, ack0 = ack_cnt;
    bresp_cfg = bresp; rresp_cfg = rresp;
    exp_addr = 40'(adr) << 3;
    exp_lat  = 3 + (we ? ((aw_dly > w_dly ? aw_dly : w_dly) + b_dly) : (ar_dly + r_dly));
    wb_xfer(we, adr, dat, sel, hold, lat, rd, err);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("ack_count", 64'(ack_cnt - ack0), 64'd1);
    if (we) begin
      chk("awaddr", 64'(aw_addr_q), 64'(exp_addr));
      chk("wdata", w_data_q, dat);
      chk("wstrb", 64'(w_strb_q), 64'(sel));
      chk("aw_hs", 64'(aw_hs - aw0), 64'd1);
      chk("w_hs", 64'(w_hs - w0), 64'd1);
      chk("b_hs", 64'(b_hs - b0), 64'd1);
      chk("ar_hs_w", 64'(ar_hs - ar0), 64'd0);
      chk("awvalid_cycles", 64'(aw_high - awh0), 64'(aw_dly + 1));
      chk("wvalid_cycles", 64'(w_high - wh0), 64'(w_dly + 1));
      chk("err_w", 64'(err), 64'(bresp != 2'b00));
      chk("dat_o_kept", rd, last_rd);
      if (!ref_mem.exists(adr)) ref_mem[adr] = 64'h0;
      for (int i = 0; i < 8; i++)
        if (sel[i]) ref_mem[adr][8*i +: 8] = dat[8*i +: 8];
    end else begin
      exp_rd = ref_mem.exists(adr) ? ref_mem[adr] : 64'h0;
      chk("araddr", 64'(ar_addr_q), 64'(exp_addr));
      chk("rdata", rd, exp_rd);
      chk("ar_hs", 64'(ar_hs - ar0), 64'd1);
      chk("r_hs", 64'(r_hs - r0), 64'd1);
      chk("aw_hs_r", 64'(aw_hs - aw0), 64'd0);
      chk("err_r", 64'(err), 64'(rresp != 2'b00));
      last_rd = exp_rd;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(s_wb_ack_o), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_awvalid", 64'(m_axi4l_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_axi4l_wvalid), 64'd0);
    chk("rst_bready", 64'(m_axi4l_bready), 64'd0);
    chk("rst_arvalid", 64'(m_axi4l_arvalid), 64'd0);
    chk("rst_rready", 64'(m_axi4l_rready), 64'd0);
    chk("rst_dat_o", s_wb_dat_o, 64'd0);
    chk("rst_awaddr", 64'(m_axi4l_awaddr), 64'd0);
    chk("rst_wstrb", 64'(m_axi4l_wstrb), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_txn(1'b1, 37'h10, 64'h1122334455667788, 8'hFF, 1'b0, 2'b00, 2'b00);
    chk("awaddr_0x80", 64'(aw_addr_q), 64'h80);

    aw_dly = 4;
    do_txn(1'b1, 37'h11, 64'hA5A5_0000_FFFF_1234, 8'h0F, 1'b0, 2'b00, 2'b00);
    aw_dly = 0;

    do_txn(1'b1, 37'h2, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0, 2'b00, 2'b00);
    r_dly = 5;
    do_txn(1'b0, 37'h2, 64'h0, 8'h00, 1'b0, 2'b00, 2'b00);
    chk("araddr_0x10", 64'(ar_addr_q), 64'h10);
    r_dly = 0;
    do_txn(1'b1, 37'h3, 64'h0123_4567_89AB_CDEF, 8'h3C, 1'b0, 2'b00, 2'b00);
    chk("dat_o_held", s_wb_dat_o, 64'hDEADBEEF_CAFEF00D);

    do_txn(1'b1, 37'h4, 64'h5555_6666_7777_8888, 8'hFF, 1'b0, 2'b10, 2'b00);
    do_txn(1'b0, 37'h4, 64'h0, 8'h00, 1'b0, 2'b00, 2'b11);
    do_txn(1'b0, 37'h4, 64'h0, 8'h00, 1'b0, 2'b00, 2'b00);

    do_txn(1'b1, 37'h6, 64'($urandom) << 32 | 64'($urandom), 8'($urandom), 1'b1, 2'b00, 2'b00);
    do_txn(1'b0, 37'h6, 64'h0, 8'h00, 1'b1, 2'b00, 2'b00);
    do_txn(1'b1, 37'h7, 64'($urandom) << 32 | 64'($urandom), 8'hFF, 1'b1, 2'b00, 2'b00);
    s_wb_stb_i = 1'b0;

    b_dly = 20;
    s_wb_stb_i = 1'b1; s_wb_we_i = 1'b1; s_wb_adr_i = 37'h100;
    s_wb_dat_i = 64'hFFFF_0000_FFFF_0000; s_wb_sel_i = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("waitb_bready", 64'(m_axi4l_bready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_bready", 64'(m_axi4l_bready), 64'd0);
    chk("rst_mid_ack", 64'(s_wb_ack_o), 64'd0);
    chk("rst_mid_awvalid", 64'(m_axi4l_awvalid), 64'd0);
    s_wb_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    b_dly = 0;
    last_rd = 64'h0;
    chk("rst_mid_dat_o", s_wb_dat_o, 64'h0);
    @(posedge clk); #1;
    do_txn(1'b1, 37'h8, 64'h0BAD_F00D_1357_2468, 8'hFF, 1'b0, 2'b00, 2'b00);
    do_txn(1'b0, 37'h8, 64'h0, 8'h00, 1'b0, 2'b00, 2'b00);

    for (int n = 0; n < 24; n++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      do_txn(1'($urandom), 37'($urandom_range(0, 15)),
             64'($urandom) << 32 | 64'($urandom), 8'($urandom),
             (n != 23) && 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end
    s_wb_stb_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
